// File: rtl/cpu6_memarb.sv
// Single-port RAM arbiter between cpu6 fetch and data ports: data-first priority with a
// starvation guard for fetch. Optional stat counter enabled by CPU6_MEMARB_STATS_EN.
module cpu6_memarb #(
  parameter int XLEN        = 32,
  parameter int MAX_DSTREAK = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic            if_gnt,
  output logic            if_stall,
  output logic            if_rvalid,
  output logic [XLEN-1:0] if_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [XLEN-1:0] d_rdata,
  output logic            mem_en,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [15:0]     stat_conflict
);

  typedef enum logic [1:0] {RSP_NONE, RSP_IF, RSP_D} rsp_e;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_DSTREAK);

  rsp_e       rsp_owner, rsp_next;
  logic [3:0] streak;
  logic       force_if;

  // Grants are held off while reset is asserted so the RAM sees no traffic.
  assign force_if = if_req & (streak == STREAK_MAX);
  assign d_gnt    = reset & d_req & ~force_if;
  assign if_gnt   = reset & if_req & ~d_gnt;
  assign if_stall = if_req & ~if_gnt;

  assign mem_en    = if_gnt | d_gnt;
  assign mem_we    = d_gnt & d_we;
  assign mem_addr  = d_gnt ? d_addr : (if_gnt ? if_addr : '0);
  assign mem_wdata = d_gnt ? d_wdata : '0;

  always_comb begin
    rsp_next = RSP_NONE;
    if (if_gnt)             rsp_next = RSP_IF;
    else if (d_gnt && !d_we) rsp_next = RSP_D;
  end

  always_ff @(posedge clk) begin
    if (!reset) rsp_owner <= RSP_NONE;
    else        rsp_owner <= rsp_next;
  end

  // A response still in flight when reset drops is discarded immediately.
  assign if_rvalid = reset & (rsp_owner == RSP_IF);
  assign d_rvalid  = reset & (rsp_owner == RSP_D);
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign d_rdata   = d_rvalid  ? mem_rdata : '0;

  always_ff @(posedge clk) begin
    if (!reset)                streak <= 4'd0;
    else if (if_gnt || !if_req) streak <= 4'd0;
    else if (d_gnt && streak != 4'hF) streak <= streak + 4'd1;
  end

`ifdef CPU6_MEMARB_STATS_EN
  logic [15:0] conflict_cnt;

  always_ff @(posedge clk) begin
    if (!reset) conflict_cnt <= 16'h0;
    else if (if_req && d_req && conflict_cnt != 16'hFFFF) conflict_cnt <= conflict_cnt + 16'h1;
  end

  assign stat_conflict = conflict_cnt;
`else
  assign stat_conflict = 16'h0;
`endif

endmodule

// File: tb/tb_cpu6_memarb.sv
// Directed bench for cpu6_memarb with a behavioural single-port RAM (1-cycle read).
module tb_cpu6_memarb;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            if_req, d_req, d_we;
  logic [XLEN-1:0] if_addr, d_addr, d_wdata;
  logic            if_gnt, if_stall, if_rvalid, d_gnt, d_rvalid;
  logic [XLEN-1:0] if_rdata, d_rdata;
  logic            mem_en, mem_we;
  logic [XLEN-1:0] mem_addr, mem_wdata, mem_rdata;
  logic [15:0]     stat_conflict;

  int checks = 0;
  int errors = 0;

  cpu6_memarb #(.XLEN(XLEN), .MAX_DSTREAK(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_stall(if_stall),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stat_conflict(stat_conflict)
  );

  always #5 clk = ~clk;

  // RAM model: unwritten words read back a fixed address-derived pattern.
  bit [31:0] ram     [0:4095];
  bit        written [0:4095];
  logic [31:0] rdq = '0;
  assign mem_rdata = rdq;

  function automatic logic [31:0] ram_init(input logic [31:0] addr);
    return 32'hA500_0000 | {20'h0, addr[13:2]};
  endfunction

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr[13:2]]     <= mem_wdata;
        written[mem_addr[13:2]] <= 1'b1;
      end else begin
        rdq <= written[mem_addr[13:2]] ? ram[mem_addr[13:2]] : ram_init(mem_addr);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
  endtask

  task automatic test_reset();
    idle();
    reset = 0;
    tick(); tick();
    #1;
    checks++; if (if_rvalid !== 1'b0) begin errors++; $display("FAIL reset_if_rvalid got %0b exp 0", if_rvalid); end
    checks++; if (d_rvalid !== 1'b0) begin errors++; $display("FAIL reset_d_rvalid got %0b exp 0", d_rvalid); end
    checks++; if (stat_conflict !== 16'h0) begin errors++; $display("FAIL reset_stat got %h exp 0", stat_conflict); end
    checks++; if (mem_en !== 1'b0 || mem_addr !== '0) begin errors++; $display("FAIL reset_mem got en=%0b addr=%h exp 0/0", mem_en, mem_addr); end
    reset = 1;
    tick();
  endtask

  task automatic test_fetch();
    if_req = 1; if_addr = 32'h100;
    #1;
    checks++; if (if_gnt !== 1'b1 || if_stall !== 1'b0) begin errors++; $display("FAIL fetch_gnt got gnt=%0b stall=%0b exp 1/0", if_gnt, if_stall); end
    checks++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h100) begin errors++; $display("FAIL fetch_mem got en=%0b we=%0b addr=%h exp 1/0/100", mem_en, mem_we, mem_addr); end
    tick();
    idle();
    #1;
    checks++; if (if_rvalid !== 1'b1 || if_rdata !== ram_init(32'h100)) begin errors++; $display("FAIL fetch_rsp got v=%0b d=%h exp 1/%h", if_rvalid, if_rdata, ram_init(32'h100)); end
    checks++; if (d_rvalid !== 1'b0 || d_rdata !== '0) begin errors++; $display("FAIL fetch_d_quiet got v=%0b d=%h exp 0/0", d_rvalid, d_rdata); end
    tick();
    checks++; if (if_rvalid !== 1'b0 || if_rdata !== '0) begin errors++; $display("FAIL fetch_rsp_end got v=%0b d=%h exp 0/0", if_rvalid, if_rdata); end
  endtask

  task automatic test_load_vs_fetch();
    d_req = 1; d_we = 0; d_addr = 32'h2000; if_req = 1; if_addr = 32'h104;
    #1;
    checks++; if (d_gnt !== 1'b1 || if_gnt !== 1'b0 || if_stall !== 1'b1) begin errors++; $display("FAIL lvf_arb got d=%0b if=%0b stall=%0b exp 1/0/1", d_gnt, if_gnt, if_stall); end
    checks++; if (mem_addr !== 32'h2000 || mem_we !== 1'b0) begin errors++; $display("FAIL lvf_mem got addr=%h we=%0b exp 2000/0", mem_addr, mem_we); end
    tick();
    d_req = 0;
    #1;
    checks++; if (d_rvalid !== 1'b1 || d_rdata !== ram_init(32'h2000)) begin errors++; $display("FAIL lvf_d_rsp got v=%0b d=%h exp 1/%h", d_rvalid, d_rdata, ram_init(32'h2000)); end
    checks++; if (if_gnt !== 1'b1 || if_stall !== 1'b0 || mem_addr !== 32'h104) begin errors++; $display("FAIL lvf_if_gnt got gnt=%0b stall=%0b addr=%h exp 1/0/104", if_gnt, if_stall, mem_addr); end
    tick();
    idle();
    #1;
    checks++; if (if_rvalid !== 1'b1 || if_rdata !== ram_init(32'h104) || d_rvalid !== 1'b0) begin errors++; $display("FAIL lvf_if_rsp got v=%0b d=%h dv=%0b exp 1/%h/0", if_rvalid, if_rdata, d_rvalid, ram_init(32'h104)); end
    tick();
  endtask

  task automatic test_store();
    d_req = 1; d_we = 1; d_addr = 32'h2004; d_wdata = 32'hDEADBEEF;
    #1;
    checks++; if (d_gnt !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 32'hDEADBEEF || mem_addr !== 32'h2004) begin errors++; $display("FAIL store_mem got gnt=%0b we=%0b wd=%h a=%h exp 1/1/deadbeef/2004", d_gnt, mem_we, mem_wdata, mem_addr); end
    tick();
    d_we = 0; d_wdata = '0;
    #1;
    checks++; if (d_rvalid !== 1'b0) begin errors++; $display("FAIL store_no_rvalid got %0b exp 0", d_rvalid); end
    checks++; if (d_gnt !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL store_reload_gnt got gnt=%0b we=%0b exp 1/0", d_gnt, mem_we); end
    tick();
    idle();
    #1;
    checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL store_readback got v=%0b d=%h exp 1/deadbeef", d_rvalid, d_rdata); end
    tick();
  endtask

  // Data traffic with no waiting fetch must not build up a streak.
  task automatic test_streak_clear();
    logic exp_if;
    d_req = 1; d_we = 0; d_addr = 32'h2004;
    for (int k = 0; k < 6; k++) begin
      #1;
      checks++; if (d_gnt !== 1'b1) begin errors++; $display("FAIL streak_solo_d%0d got %0b exp 1", k, d_gnt); end
      if (k > 0) begin
        checks++; if (d_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL streak_solo_rd%0d got %h exp deadbeef", k, d_rdata); end
      end
      tick();
    end
    if_req = 1; if_addr = 32'h108;
    for (int k = 0; k < 5; k++) begin
      #1;
      exp_if = (k == 4);
      checks++; if (if_gnt !== exp_if || d_gnt !== !exp_if) begin errors++; $display("FAIL streak_join%0d got if=%0b d=%0b exp if=%0b", k, if_gnt, d_gnt, exp_if); end
      tick();
    end
    idle();
    tick();
  endtask

  task automatic test_starvation();
    logic exp_if, exp_drv;
    d_req = 1; d_we = 0; d_addr = 32'h2000; if_req = 1; if_addr = 32'h100;
    for (int k = 0; k < 10; k++) begin
      #1;
      exp_if = ((k % 5) == 4);
      checks++; if (if_gnt !== exp_if || d_gnt !== !exp_if) begin errors++; $display("FAIL starve_c%0d got if=%0b d=%0b exp if=%0b", k, if_gnt, d_gnt, exp_if); end
      if (k > 0) begin
        exp_drv = (((k - 1) % 5) != 4);
        checks++; if (d_rvalid !== exp_drv || if_rvalid !== !exp_drv) begin errors++; $display("FAIL starve_rsp%0d got dv=%0b iv=%0b exp dv=%0b", k, d_rvalid, if_rvalid, exp_drv); end
      end
      tick();
    end
    idle();
    #1;
    checks++; if (if_rvalid !== 1'b1 || if_rdata !== ram_init(32'h100)) begin errors++; $display("FAIL starve_last got v=%0b d=%h exp 1/%h", if_rvalid, if_rdata, ram_init(32'h100)); end
    tick();
  endtask

  task automatic test_reset_midop();
    d_req = 1; d_we = 0; d_addr = 32'h2000;
    #1;
    checks++; if (d_gnt !== 1'b1) begin errors++; $display("FAIL rmid_gnt got %0b exp 1", d_gnt); end
    tick();
    reset = 0; d_req = 1; if_req = 1; if_addr = 32'h100;
    #1;
    checks++; if (d_rvalid !== 1'b0 || d_rdata !== '0) begin errors++; $display("FAIL rmid_drop got v=%0b d=%h exp 0/0", d_rvalid, d_rdata); end
    checks++; if (d_gnt !== 1'b0 || if_gnt !== 1'b0 || mem_en !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL rmid_quiet got dg=%0b ig=%0b en=%0b we=%0b exp 0", d_gnt, if_gnt, mem_en, mem_we); end
    idle();
    tick(); tick();
    reset = 1;
    #1;
    checks++; if (d_rvalid !== 1'b0 || if_rvalid !== 1'b0) begin errors++; $display("FAIL rmid_release got dv=%0b iv=%0b exp 0/0", d_rvalid, if_rvalid); end
    if_req = 1; if_addr = 32'h10C;
    #1;
    checks++; if (if_gnt !== 1'b1 || mem_addr !== 32'h10C) begin errors++; $display("FAIL rmid_resume got gnt=%0b addr=%h exp 1/10c", if_gnt, mem_addr); end
    tick();
    idle();
    #1;
    checks++; if (if_rvalid !== 1'b1 || if_rdata !== ram_init(32'h10C)) begin errors++; $display("FAIL rmid_resume_rsp got v=%0b d=%h exp 1/%h", if_rvalid, if_rdata, ram_init(32'h10C)); end
    tick();
  endtask

  task automatic test_stats();
    logic [15:0] exp_stat;
`ifdef CPU6_MEMARB_STATS_EN
    exp_stat = 16'd10;
`else
    exp_stat = 16'd0;
`endif
    idle();
    reset = 0;
    tick();
    reset = 1;
    #1;
    checks++; if (stat_conflict !== 16'h0) begin errors++; $display("FAIL stats_clear got %h exp 0", stat_conflict); end
    d_req = 1; d_addr = 32'h2000; if_req = 1; if_addr = 32'h100;
    for (int k = 0; k < 10; k++) tick();
    idle();
    #1;
    checks++; if (stat_conflict !== exp_stat) begin errors++; $display("FAIL stats_count got %0d exp %0d", stat_conflict, exp_stat); end
    tick();
    checks++; if (stat_conflict !== exp_stat) begin errors++; $display("FAIL stats_hold got %0d exp %0d", stat_conflict, exp_stat); end
  endtask

  initial begin
    idle();
    reset = 0;
    test_reset();
    test_fetch();
    test_load_vs_fetch();
    test_store();
    test_streak_clear();
    test_starvation();
    test_reset_midop();
    test_stats();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
